// File: rtl/reg_dump_pkg.sv
// Shared register-file geometry and the dump reader's state encoding.
package reg_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Debug read-side initiator: walks the register file through one read port and
// streams (address, data) pairs on a valid/ready interface while stalling the CPU.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS  = REG_COUNT,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int DATA_W    = REG_DATA_W,
  parameter int FIRST_REG = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] Rd_addr,
  input  logic [DATA_W-1:0] Rd_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [ADDR_W-1:0] Out_addr,
  output logic [DATA_W-1:0] Out_data,
  output logic              Stall_cpu,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state;
  logic [ADDR_W-1:0] count;

  assign Rd_addr = count;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      count     <= FIRST_ADDR;
      Out_valid <= 1'b0;
      Out_addr  <= '0;
      Out_data  <= '0;
      Stall_cpu <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      // Abort outranks every state transition once a dump is under way.
      if (Abort && (state != IDLE)) begin
        state     <= IDLE;
        count     <= FIRST_ADDR;
        Out_valid <= 1'b0;
        Stall_cpu <= 1'b0;
        Busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (Start && !Abort) begin
              state     <= READ;
              count     <= FIRST_ADDR;
              Stall_cpu <= 1'b1;
              Busy      <= 1'b1;
            end
          end
          READ: begin
            Out_data  <= Rd_data;
            Out_addr  <= count;
            Out_valid <= 1'b1;
            state     <= SEND;
          end
          SEND: begin
            if (Out_ready) begin
              Out_valid <= 1'b0;
              if (count == LAST_ADDR) begin
                state <= FIN;
                Done  <= 1'b1;
              end else begin
                count <= count + 1'b1;
                state <= READ;
              end
            end
          end
          FIN: begin
            Stall_cpu <= 1'b0;
            Busy      <= 1'b0;
            count     <= FIRST_ADDR;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed-plus-random bench for reg_dump_reader against a register file holding A500_0000+i.
module tb_reg_dump_reader;

  localparam int NUM = 32;

  logic        Clk;
  logic        Rst_n;
  logic        Start, Abort, Out_ready;
  logic [4:0]  Rd_addr, Out_addr;
  logic [31:0] Rd_data, Out_data;
  logic        Out_valid, Stall_cpu, Busy, Done;

  logic        Start1, Abort1, Out_ready1;
  logic [4:0]  Rd_addr1, Out_addr1;
  logic [31:0] Rd_data1, Out_data1;
  logic        Out_valid1, Stall_cpu1, Busy1, Done1;

  int checks   = 0;
  int failures = 0;

  assign Rd_data  = 32'hA500_0000 + {27'd0, Rd_addr};
  assign Rd_data1 = 32'hA500_0000 + {27'd0, Rd_addr1};

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort),
    .Rd_addr(Rd_addr), .Rd_data(Rd_data),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_addr(Out_addr), .Out_data(Out_data),
    .Stall_cpu(Stall_cpu), .Busy(Busy), .Done(Done)
  );

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(30)) dut_hi (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start1), .Abort(Abort1),
    .Rd_addr(Rd_addr1), .Rd_data(Rd_data1),
    .Out_valid(Out_valid1), .Out_ready(Out_ready1),
    .Out_addr(Out_addr1), .Out_data(Out_data1),
    .Stall_cpu(Stall_cpu1), .Busy(Busy1), .Done(Done1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One dump on dut: model expects words 0..NUM-1 in order, each carrying A500_0000+addr.
  task automatic dump(input bit rnd, input int bp_addr, input int start_addr, input int abort_addr);
    int e, cyc, bp_left;
    bit prev_hold, hs, aborted;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    e = 0; cyc = 0; bp_left = 5; prev_hold = 0; aborted = 0;
    h_addr = '0; h_data = '0;
    Out_ready = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("busy_after_start", Busy, 1);
    chk("stall_after_start", Stall_cpu, 1);
    chk("valid_in_read", Out_valid, 0);
    cyc = 1;
    while (e < NUM && !aborted && cyc <= 2000) begin
      Out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (e == bp_addr && Out_valid && bp_left > 0) begin
        Out_ready = 1'b0;
        bp_left--;
      end
      if (e == start_addr && Out_valid) Start = 1'b1;
      chk("done_mid", Done, 0);
      chk("stall_mid", Stall_cpu, 1);
      chk("busy_mid", Busy, 1);
      if (Out_valid) begin
        chk("out_addr", Out_addr, e);
        chk("out_data", Out_data, 32'hA500_0000 + e);
      end
      if (prev_hold) begin
        chk("hold_valid", Out_valid, 1);
        chk("hold_addr", Out_addr, h_addr);
        chk("hold_data", Out_data, h_data);
      end
      if (e == abort_addr && Out_valid) begin
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("abort_valid", Out_valid, 0);
        chk("abort_stall", Stall_cpu, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        tick();
        chk("abort_done_later", Done, 0);
        chk("abort_stays_idle", Busy, 0);
        aborted = 1;
      end else begin
        hs        = Out_valid && Out_ready;
        prev_hold = Out_valid && !Out_ready;
        h_addr    = Out_addr;
        h_data    = Out_data;
        tick();
        Start = 1'b0;
        cyc++;
        if (hs) e++;
      end
    end
    Out_ready = 1'b0;
    if (!aborted) begin
      chk("dump_complete", e, NUM);
      chk("fin_done", Done, 1);
      chk("fin_stall", Stall_cpu, 1);
      chk("fin_valid", Out_valid, 0);
      if (!rnd && bp_addr < 0 && start_addr < 0) chk("done_latency", cyc, 2 * NUM + 1);
      tick();
      chk("post_done", Done, 0);
      chk("post_stall", Stall_cpu, 0);
      chk("post_busy", Busy, 0);
      chk("post_rd_addr", Rd_addr, 0);
    end
  endtask

  initial begin
    int e1;
    bit seen;
    Rst_n = 1'b0; Start = 1'b0; Abort = 1'b0; Out_ready = 1'b0;
    Start1 = 1'b0; Abort1 = 1'b0; Out_ready1 = 1'b1;
    tick(); tick();
    chk("rst_valid", Out_valid, 0);
    chk("rst_addr", Out_addr, 0);
    chk("rst_data", Out_data, 0);
    chk("rst_stall", Stall_cpu, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_rd_addr", Rd_addr, 0);
    chk("rst_rd_addr_hi", Rd_addr1, 30);
    Rst_n = 1'b1;
    tick();

    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("idle_abort_busy", Busy, 0);

    dump(1'b0, -1, -1, -1);
    dump(1'b1, 7, 12, -1);
    dump(1'b1, -1, -1, 20);
    dump(1'b1, -1, -1, -1);

    // Reset in the middle of a dump.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      Out_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    Rst_n = 1'b0;
    tick(); tick();
    chk("mrst_valid", Out_valid, 0);
    chk("mrst_addr", Out_addr, 0);
    chk("mrst_data", Out_data, 0);
    chk("mrst_stall", Stall_cpu, 0);
    chk("mrst_busy", Busy, 0);
    chk("mrst_done", Done, 0);
    chk("mrst_rd_addr", Rd_addr, 0);
    Rst_n = 1'b1;
    Out_ready = 1'b0;
    tick();
    chk("mrst_after_done", Done, 0);
    chk("mrst_after_busy", Busy, 0);

    // FIRST_REG=30 instance.
    Start1 = 1'b1; Abort1 = 1'b1;
    tick();
    Start1 = 1'b0; Abort1 = 1'b0;
    chk("hi_start_abort_busy", Busy1, 0);
    chk("hi_start_abort_stall", Stall_cpu1, 0);
    tick();
    chk("hi_start_abort_valid", Out_valid1, 0);
    Start1 = 1'b1;
    tick();
    Start1 = 1'b0;
    e1 = 30; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (Out_valid1) begin
        chk("hi_addr", Out_addr1, e1);
        chk("hi_data", Out_data1, 32'hA500_0000 + e1);
        e1++;
      end
      if (Done1) seen = 1;
      tick();
    end
    chk("hi_words", e1 - 30, 2);
    chk("hi_done_seen", seen, 1);
    chk("hi_idle_after", Busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
